// File: rtl/tone_pkg.sv
// Shared constants and types for the tone_player note generator.
// Holds note half-periods for a 100 MHz clock, the FSM state enum and default tick length.
package tone_pkg;

   localparam int TICK_CYCLES_DEF = 100_000;

   localparam logic [17:0] NOTE_C4   = 18'd191_110;
   localparam logic [17:0] NOTE_D4   = 18'd170_265;
   localparam logic [17:0] NOTE_E4   = 18'd151_685;
   localparam logic [17:0] NOTE_F4   = 18'd143_172;
   localparam logic [17:0] NOTE_G4   = 18'd127_551;
   localparam logic [17:0] NOTE_A4   = 18'd113_636;
   localparam logic [17:0] NOTE_B4   = 18'd101_239;
   localparam logic [17:0] NOTE_C5   = 18'd95_557;
   localparam logic [17:0] NOTE_REST = 18'd0;

   typedef enum logic {
      IDLE = 1'b0,
      PLAY = 1'b1
   } state_e;

endpackage

// File: rtl/tone_player_tick_prescaler.sv
// Free-running prescaler that emits a one-cycle tick every TICK_CYCLES enabled cycles.
// Ports: clk, rst (async high), clr (sync zero), en (count), tick (pulse on last count).
module tick_prescaler #(
   parameter int TICK_CYCLES = 100_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int PRE_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [PRE_W-1:0] LAST = PRE_W'(TICK_CYCLES - 1);

   logic [PRE_W-1:0] pre_q;
   logic [PRE_W-1:0] pre_d;

   assign tick = en && (pre_q == LAST);

   always_comb begin
      pre_d = pre_q;
      if (clr) begin
         pre_d = '0;
      end else if (en) begin
         pre_d = (pre_q == LAST) ? '0 : pre_q + PRE_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pre_q <= '0;
      else     pre_q <= pre_d;
   end

endmodule

// File: rtl/tone_player.sv
// Square-wave note generator: one note per start, programmable pitch and duration.
// Ports: start/half_period/duration_ms/stop in; ready, busy, done pulse, tone out.
import tone_pkg::*;

module tone_player #(
   parameter int TICK_CYCLES = TICK_CYCLES_DEF,
   parameter int DIV_W       = 18,
   parameter int DUR_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [DIV_W-1:0] half_period,
   input  logic [DUR_W-1:0] duration_ms,
   input  logic             stop,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic             tone
);

   state_e           state_q, state_d;
   logic [DIV_W-1:0] hp_q, hp_d;
   logic [DUR_W-1:0] dur_q, dur_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [DUR_W-1:0] tcnt_q, tcnt_d;
   logic             tone_q, tone_d;
   logic             done_q, done_d;
   logic             tick;
   logic             last;

   tick_prescaler #(
      .TICK_CYCLES(TICK_CYCLES)
   ) u_pre (
      .clk (clk),
      .rst (rst),
      .clr ((state_q == IDLE) || stop),
      .en  (state_q == PLAY),
      .tick(tick)
   );

   // dur==0 still spends one cycle in PLAY
   assign last = (dur_q == '0) ||
                 (tick && (tcnt_q == dur_q - DUR_W'(1)));

   always_comb begin
      state_d = state_q;
      hp_d    = hp_q;
      dur_d   = dur_q;
      div_d   = div_q;
      tcnt_d  = tcnt_q;
      tone_d  = tone_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = PLAY;
               hp_d    = half_period;
               dur_d   = duration_ms;
               div_d   = '0;
               tcnt_d  = '0;
               tone_d  = 1'b0;
            end
         end
         PLAY: begin
            if (stop || last) begin
               // stop beats a normal finish in the same cycle
               state_d = IDLE;
               tone_d  = 1'b0;
               div_d   = '0;
               tcnt_d  = '0;
               done_d  = !stop;
            end else begin
               if (hp_q != '0) begin
                  if (div_q == hp_q - DIV_W'(1)) begin
                     div_d  = '0;
                     tone_d = !tone_q;
                  end else begin
                     div_d = div_q + DIV_W'(1);
                  end
               end
               if (tick) tcnt_d = tcnt_q + DUR_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         hp_q    <= '0;
         dur_q   <= '0;
         div_q   <= '0;
         tcnt_q  <= '0;
         tone_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hp_q    <= hp_d;
         dur_q   <= dur_d;
         div_q   <= div_d;
         tcnt_q  <= tcnt_d;
         tone_q  <= tone_d;
         done_q  <= done_d;
      end
   end

   assign ready = (state_q == IDLE);
   assign busy  = (state_q == PLAY);
   assign done  = done_q;
   assign tone  = tone_q;

endmodule

// File: tb/tb_tone_player.sv
// Self-checking bench for tone_player with a small tick length.
// Expected waveforms come from the note rules: tone=(k/hp)%2, length=dur*TICK.
module tb_tone_player;

   localparam int TICK = 10;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [17:0] half_period = '0;
   logic [15:0] duration_ms = '0;
   logic        stop = 1'b0;
   logic        ready, busy, done, tone;

   int total = 0;
   int bad   = 0;

   tone_player #(
      .TICK_CYCLES(TICK),
      .DIV_W(18),
      .DUR_W(16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .half_period(half_period),
      .duration_ms(duration_ms),
      .stop       (stop),
      .ready      (ready),
      .busy       (busy),
      .done       (done),
      .tone       (tone)
   );

   always #5 clk = ~clk;

   // Called at a negedge while idle; returns at the negedge of the
   // first idle cycle after the note, so a following call is back-to-back.
   task automatic play_note(input int hp, input int dur, input int stop_at,
                            input bit noise, input string tag);
      int   len;
      int   lastk;
      bit   ab;
      logic ptone, pbusy, exp_t;
      len   = (dur == 0) ? 1 : dur * TICK;
      ab    = (stop_at >= 0) && (stop_at < len);
      lastk = ab ? stop_at : len - 1;
      total++;
      if (ready !== 1'b1) begin
         bad++;
         $display("FAIL %s pre_ready got=%b want=1", tag, ready);
      end
      ptone       = tone;
      pbusy       = busy;
      start       = 1'b1;
      half_period = 18'(hp);
      duration_ms = 16'(dur);
      stop        = 1'b0;
      for (int k = 0; k <= lastk; k++) begin
         @(negedge clk);
         start       = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         half_period = 18'($urandom);
         duration_ms = 16'($urandom);
         stop        = ab && (k == stop_at);
         exp_t       = (hp == 0) ? 1'b0 : 1'((k / hp) % 2);
         total++;
         if (busy !== 1'b1) begin
            bad++;
            $display("FAIL %s busy k=%0d got=%b want=1", tag, k, busy);
         end
         total++;
         if (tone !== exp_t) begin
            bad++;
            $display("FAIL %s tone k=%0d got=%b want=%b", tag, k, tone, exp_t);
         end
         total++;
         if (ready !== !busy) begin
            bad++;
            $display("FAIL %s ready_vs_busy k=%0d ready=%b busy=%b", tag, k, ready, busy);
         end
         total++;
         if (done !== 1'b0) begin
            bad++;
            $display("FAIL %s done_in_play k=%0d got=%b want=0", tag, k, done);
         end
         total++;
         if (tone !== ptone && pbusy !== 1'b1) begin
            bad++;
            $display("FAIL %s tone_glitch k=%0d got=%b prev=%b", tag, k, tone, ptone);
         end
         ptone = tone;
         pbusy = busy;
      end
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      total++;
      if (busy !== 1'b0 || ready !== 1'b1) begin
         bad++;
         $display("FAIL %s end_state busy=%b ready=%b want busy=0 ready=1", tag, busy, ready);
      end
      total++;
      if (tone !== 1'b0) begin
         bad++;
         $display("FAIL %s end_tone got=%b want=0", tag, tone);
      end
      total++;
      if (done !== !ab) begin
         bad++;
         $display("FAIL %s end_done got=%b want=%b", tag, done, !ab);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      total++;
      if ({tone, done, busy, ready} !== 4'b0001) begin
         bad++;
         $display("FAIL reset tone/done/busy/ready got=%b want=0001", {tone, done, busy, ready});
      end
   endtask

   task automatic test_basic();
      play_note(3, 2, -1, 1'b0, "basic");
      @(negedge clk);
      total++;
      if (done !== 1'b0 || ready !== 1'b1) begin
         bad++;
         $display("FAIL basic done_width done=%b ready=%b want 0/1", done, ready);
      end
   endtask

   task automatic test_rest_zero();
      play_note(0, 1, -1, 1'b0, "rest");
      @(negedge clk);
      play_note(5, 0, -1, 1'b0, "zero_dur");
      @(negedge clk);
   endtask

   task automatic test_abort_back_to_back();
      play_note(3, 2, 7, 1'b0, "abort");
      play_note(3, 2, 19, 1'b0, "abort_last");
      @(negedge clk);
      play_note(3, 1, -1, 1'b0, "b2b_a");
      play_note(2, 1, -1, 1'b0, "b2b_b");
      @(negedge clk);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      total++;
      if (ready !== 1'b1 || done !== 1'b0) begin
         bad++;
         $display("FAIL stop_idle ready=%b done=%b want 1/0", ready, done);
      end
      stop = 1'b1;
      play_note(2, 1, -1, 1'b0, "start_and_stop");
      @(negedge clk);
   endtask

   task automatic test_ignored_hp1();
      play_note(3, 2, -1, 1'b1, "ignored_starts");
      @(negedge clk);
      play_note(1, 1, -1, 1'b0, "hp1");
      @(negedge clk);
   endtask

   task automatic test_random();
      for (int n = 0; n < 12; n++) begin
         int hp, dur, sa;
         hp  = $urandom_range(0, 7);
         dur = $urandom_range(0, 3);
         sa  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 30)) : -1;
         play_note(hp, dur, sa, 1'($urandom_range(0, 1)), "random");
         if ($urandom_range(0, 1) == 1) @(negedge clk);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_note();
      start       = 1'b1;
      half_period = 18'd3;
      duration_ms = 16'd2;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if (tone !== 1'b1 || busy !== 1'b1) begin
         bad++;
         $display("FAIL mid_note_pre tone=%b busy=%b want 1/1", tone, busy);
      end
      #2 rst = 1'b1;
      #1;
      total++;
      if ({tone, done, busy, ready} !== 4'b0001) begin
         bad++;
         $display("FAIL mid_note_reset tone/done/busy/ready got=%b want=0001", {tone, done, busy, ready});
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      play_note(2, 1, -1, 1'b0, "after_reset");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_rest_zero();
      test_abort_back_to_back();
      test_ignored_hp1();
      test_random();
      test_reset_mid_note();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tone_player.md
Name: tone_player

Overview:
- Parametrised square-wave note generator; successor to the fixed 440 Hz enable-gated divider.
- Plays one note per start handshake:
  - programmable half-period (pitch), including a rest
  - programmable duration in milliseconds
  - abort input
  - one-cycle done pulse
- Sits between a song sequencer (melody ROM plus FSM) and the speaker/PWM pin.

Parameters:
- TICK_CYCLES, 100_000: clk cycles per duration tick (1 ms at 100 MHz); set small for simulation.
- DIV_W, 18: width of the half_period input and the pitch divider counter.
- DUR_W, 16: width of the duration_ms input and the tick counter.

Ports:
- clk          in   1      system clock
- rst          in   1      asynchronous, active-high reset
- start        in   1      request to play a note; accepted only when ready=1
- half_period  in   DIV_W  tone half-period in clk cycles; 0 = rest (silence)
- duration_ms  in   DUR_W  note length in ticks
- stop         in   1      abort the current note
- ready        out  1      idle, able to accept start
- busy         out  1      note in progress
- done         out  1      one-cycle pulse when a note completes normally
- tone         out  1      square-wave output

Behaviour:
- Async reset clears all state immediately, including mid-note. Reset values: state=IDLE, tone=0, done=0, busy=0, ready=1, all counters 0.
- States are IDLE and PLAY. ready=(state==IDLE) and busy=(state==PLAY); both are registered-state decodes.
- IDLE→PLAY: start=1 at an edge while IDLE.
  - half_period and duration_ms are latched at that edge; inputs are don't-care afterwards.
  - div_cnt, tick_pre and tick_cnt are zeroed; tone=0.
- start while PLAY is ignored. No queueing.
- Pitch divider, in PLAY with hp≠0:
  - div_cnt counts 0..hp-1.
  - At the edge where div_cnt==hp-1: tone inverts and div_cnt returns to 0.
  - Tone period is exactly 2·hp cycles; the first toggle occurs hp cycles after entering PLAY.
  - hp=1 toggles every cycle.
  - hp=0: tone held 0 and div_cnt held 0.
- Duration:
  - tick_pre counts 0..TICK_CYCLES-1. On wrap, tick_cnt increments.
  - Final cycle of PLAY is when tick_pre==TICK_CYCLES-1 and tick_cnt==dur-1, so PLAY lasts exactly dur·TICK_CYCLES cycles.
  - At the edge after the final cycle: state=IDLE, tone=0, done=1 for one cycle.
- duration_ms=0: PLAY lasts exactly 1 cycle, tone stays 0, then done pulses.
- done is asserted in the first IDLE cycle, with ready=1. A start in that same cycle is accepted, giving back-to-back notes with exactly one idle cycle between them.
- stop=1 in PLAY: at the next edge, state=IDLE and tone=0; no done pulse.
  - stop in the final PLAY cycle: stop wins, no done.
  - stop in IDLE: no effect.
  - start and stop both high in IDLE: start accepted; stop is ignored in IDLE.
- Tone never glitches: it changes only at a divider wrap, or is forced to 0 on leaving PLAY.
- All comparisons are unsigned at full width. Counters never exceed their latched limits and never wrap past them.

Decomposition:
- Package tone_pkg:
  - note half-period constants for 100 MHz: NOTE_C4=191_110, NOTE_D4=170_265, NOTE_E4=151_685, NOTE_F4=143_172, NOTE_G4=127_551, NOTE_A4=113_636, NOTE_B4=101_239, NOTE_C5=95_557, NOTE_REST=0
  - state enum: IDLE, PLAY
  - default TICK_CYCLES
- One sub-module, tick_prescaler (params TICK_CYCLES; ports clk, rst, clr, en, tick), produces the one-cycle tick that advances tick_cnt. The pitch divider stays inline.

Test Plan (TICK_CYCLES=10, DIV_W=18, DUR_W=16):
- Reset: assert rst for 3 cycles, then release → tone=0, done=0, busy=0, ready=1. Re-assert rst mid-note → all outputs return to reset values immediately, without waiting for a clk edge.
- start with hp=3, dur=2 → busy for exactly 20 cycles. tone=0 for PLAY cycles 0–2, 1 for 3–5, 0 for 6–8, and so on, with 6 toggles total. done=1 for exactly 1 cycle after PLAY, with tone=0 and ready=1.
- Rest and zero-duration cases:
  - hp=0, dur=1 → tone constant 0 for 10 busy cycles, then done.
  - hp=5, dur=0 → busy 1 cycle, tone 0, done pulse.
- Abort and back-to-back:
  - stop at PLAY cycle 7 of hp=3, dur=2 → next cycle IDLE, tone=0, no done.
  - New start issued in the done cycle → accepted; busy rises on the next edge.
- Ignored starts and hp=1:
  - start pulses during PLAY → latched hp/dur unchanged, duration unaffected.
  - hp=1, dur=1 → tone alternates every cycle for 10 cycles (0,1,0,1…).
- Rolling checks on every test: ready == !busy; done never coincides with busy; tone only changes at a divider wrap or on exit from PLAY.
